laser_mem_arbiter: RTL and testbench
====================================

# laser_mem_arbiter

Round-robin controller that shares one single-port, tristate-bus `Memory` (AW/DW parameterised) between two requesters: the laser transmit framer (port 0, reads) and the receive deframer (port 1, reads/writes). It sequences each access, owns the memory's `address`/`re`/`we` pins, drives the shared data bus only during writes, and inserts a bus-turnaround cycle whenever the access direction changes.

## Interface
- `AW`, 8, memory address width
- `DW`, 16, memory data width

- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-high
- `req_valid`  in  2  per-port request
- `req_we`  in  2  per-port op: 1 write, 0 read
- `req_addr`  in  2×AW  per-port address (packed `[1:0][AW-1:0]`)
- `req_wdata`  in  2×DW  per-port write data
- `req_ready`  out  2  grant; request accepted on the edge where `req_valid[i] & req_ready[i]`
- `rsp_valid`  out  2  one-cycle read-data strobe to the port that issued the read
- `rsp_rdata`  out  DW  read data, valid while any `rsp_valid` bit is high
- `mem_address`  out  AW  to `Memory.address`
- `mem_re`, `mem_we`  out  1 each  to `Memory.re` / `Memory.we`
- `mem_data`  inout  DW (tri)  shared memory data bus

## Operation
- States: IDLE, ACCESS, TURN.
- IDLE: if any `req_valid`, pick winner round-robin and assert `req_ready` for that port only (combinational from state, `req_valid`, `last_grant`); latch port, op, addr, wdata; go ACCESS. No requests: stay IDLE.
- Round-robin: if both valid, winner is the port ≠ `last_grant`. `last_grant` updates on every accept. Reset value 1, so port 0 wins first contention.
- ACCESS, read: `mem_re`=1, `mem_we`=0, bus not driven by this block; `mem_data` captured into `rsp_rdata` at the closing edge; `rsp_valid[port]` high the next cycle.
- ACCESS, write: `mem_we`=1, `mem_re`=0, `mem_data` driven with latched wdata; bus released (z) in every other cycle/state.
- Leaving ACCESS: go TURN if a request is pending whose op differs from the op just performed (any valid port, checked against the would-be winner); otherwise IDLE.
- TURN: all memory controls 0, bus z, `req_ready`=0; go IDLE.
- `mem_re` and `mem_we` are never both 1; driven only from registered state/latched op.

## Timing
- Reset values: state IDLE, `mem_re`=`mem_we`=0, `mem_address`=0, bus z, `rsp_valid`=0, `rsp_rdata`=0, `last_grant`=1; `req_ready`=0 unless a `req_valid` is present in IDLE.
- Read latency: accept edge T → ACCESS during cycle T+1 → `rsp_valid` during cycle T+2.
- Write commits in `Memory` at the edge closing ACCESS (T+2 edge).
- Throughput: one access per 2 cycles same-direction; 3 cycles on direction change.
- Requester may drop `req_valid` without an accept; no state change.
- Reset mid-ACCESS: `mem_we`/`mem_re` drop and bus released immediately; interrupted write is not guaranteed committed, pending `rsp_valid` suppressed.

## Structure
- Package `laser_mem_pkg`: state enum typedef (IDLE/ACCESS/TURN), `NPORTS`=2 constant, `PORT_TX`=0/`PORT_RX`=1 constants.
- One sub-module: `rr_pick2` (combinational two-way round-robin picker: `valid[1:0]`, `last` → `grant[1:0]`).
- `Memory` instantiated only in the testbench.

## Test plan
- Reset, then port 0 read addr 0x05 (preloaded 0xBEEF) → `req_ready[0]` same cycle, `mem_re` next cycle, `rsp_valid[0]`=1 with `rsp_rdata`=0xBEEF two cycles after accept.
- Port 1 write 0x12←0xA5A5 then port 0 read 0x12 → one TURN cycle between, read returns 0xA5A5; `mem_re`&`mem_we` never simultaneous.
- Both ports valid continuously, all reads → grants alternate 0,1,0,1 starting with port 0; one accept every 2 cycles.
- Write-write-read from port 1 (0x00←1, 0x01←2, read 0x01) → writes back-to-back (no TURN), one TURN before read, returns 0x0002.
- Bus check: `mem_data` z in IDLE, TURN and read ACCESS; driven only during write ACCESS.
- Assert reset during write ACCESS → `mem_we`=0 and bus z before next edge; no `rsp_valid`; first post-reset contention granted to port 0.

Source files
------------

// File: rtl/laser_mem_pkg.sv
// Shared types and constants for the laser memory arbiter.
// State encoding and port numbering.
package laser_mem_pkg;

  localparam int NPORTS  = 2;
  localparam int PORT_TX = 0;
  localparam int PORT_RX = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    TURN   = 2'd2
  } state_t;

endpackage

// File: rtl/laser_mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: valid[1:0], last -> one-hot grant[1:0].
// On contention the port that did not win last time is chosen.
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/laser_mem_arbiter.sv
// Shares one single-port tristate memory between tx framer (port 0)
// and rx deframer (port 1); ports: req/rsp per port, mem_* pins.
module laser_mem_arbiter
  import laser_mem_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  input  logic [1:0]           req_we,
  input  logic [1:0][AW-1:0]   req_addr,
  input  logic [1:0][DW-1:0]   req_wdata,
  output logic [1:0]           req_ready,
  output logic [1:0]           rsp_valid,
  output logic [DW-1:0]        rsp_rdata,
  output logic [AW-1:0]        mem_address,
  output logic                 mem_re,
  output logic                 mem_we,
  inout  tri   [DW-1:0]        mem_data
);

  state_t        state_q;
  state_t        state_d;
  logic          port_q;
  logic          op_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          last_q;
  logic [1:0]    rsp_valid_q;
  logic [DW-1:0] rdata_q;

  logic [1:0]    grant;
  logic          win_port;
  logic          win_we;
  logic          any_req;
  logic          accept;

  rr_pick2 u_pick (
    .valid (req_valid),
    .last  (last_q),
    .grant (grant)
  );

  assign any_req  = |req_valid;
  assign win_port = grant[1];
  assign win_we   = req_we[win_port];
  assign accept   = (state_q == IDLE) && any_req;

  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          req_ready = grant;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        // Turnaround only if the next winner reverses direction.
        if (any_req && (win_we != op_q))
          state_d = TURN;
        else
          state_d = IDLE;
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      port_q      <= 1'b0;
      op_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      last_q      <= 1'b1;
      rsp_valid_q <= 2'b00;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= 2'b00;
      if (accept) begin
        port_q  <= win_port;
        op_q    <= win_we;
        addr_q  <= req_addr[win_port];
        wdata_q <= req_wdata[win_port];
        last_q  <= win_port;
      end
      if ((state_q == ACCESS) && !op_q) begin
        rsp_valid_q[port_q] <= 1'b1;
        rdata_q             <= mem_data;
      end
    end
  end

  // Strobes come straight from registered state so they drop
  // the instant reset is asserted.
  assign mem_re      = (state_q == ACCESS) && !op_q;
  assign mem_we      = (state_q == ACCESS) && op_q;
  assign mem_address = addr_q;
  assign mem_data    = mem_we ? wdata_q : {DW{1'bz}};

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_laser_mem_arbiter.sv
// Directed bench for laser_mem_arbiter with a behavioural memory.
// Idle bus is held at a keeper pattern to expose stray drives.
module tb_laser_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam logic [DW-1:0] KEEP = 16'h5A3C;

  logic               clock;
  logic               reset;
  logic [1:0]         req_valid;
  logic [1:0]         req_we;
  logic [1:0][AW-1:0] req_addr;
  logic [1:0][DW-1:0] req_wdata;
  logic [1:0]         req_ready;
  logic [1:0]         rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic [AW-1:0]      mem_address;
  logic               mem_re;
  logic               mem_we;
  wire  [DW-1:0]      mem_data;

  logic [DW-1:0] mem [256];
  logic          pre_en;
  logic [AW-1:0] pre_a;
  logic [DW-1:0] pre_d;
  logic          mon_en;

  int n_chk;
  int n_err;

  laser_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .mem_address (mem_address),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .mem_data    (mem_data)
  );

  assign mem_data = mem_re ? mem[mem_address] :
                    (!mem_we ? KEEP : {DW{1'bz}});

  always @(posedge clock) begin
    if (mem_we)
      mem[mem_address] <= mem_data;
    else if (pre_en)
      mem[pre_a] <= pre_d;
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clock)
    if (mon_en)
      chk("re_we_excl", {31'b0, mem_re & mem_we}, 32'd0);

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in;
    req_valid = 2'b00;
    req_we    = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic preload(input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    pre_en = 1'b1;
    pre_a  = a;
    pre_d  = d;
    step();
    pre_en = 1'b0;
  endtask

  task automatic pulse_reset;
    #2 reset = 1'b1;
    step();
    #2 reset = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_err  = 0;
    mon_en = 1'b0;
    pre_en = 1'b0;
    pre_a  = '0;
    pre_d  = '0;
    reset  = 1'b1;
    idle_in();
    preload(8'h05, 16'hBEEF);
    preload(8'h06, 16'h1234);
    #2 reset = 1'b0;
    step();
    mon_en = 1'b1;

    // reset state
    chk("rst_re", {31'b0, mem_re}, 0);
    chk("rst_we", {31'b0, mem_we}, 0);
    chk("rst_addr", {24'b0, mem_address}, 0);
    chk("rst_rspv", {30'b0, rsp_valid}, 0);
    chk("rst_rdata", {16'b0, rsp_rdata}, 0);
    chk("rst_ready", {30'b0, req_ready}, 0);
    chk("rst_bus", {16'b0, mem_data}, {16'b0, KEEP});

    // port 0 read 0x05
    req_valid   = 2'b01;
    req_addr[0] = 8'h05;
    #1 chk("t1_ready", {30'b0, req_ready}, 32'h1);
    step();
    idle_in();
    #1;
    chk("t1_re", {31'b0, mem_re}, 1);
    chk("t1_we", {31'b0, mem_we}, 0);
    chk("t1_addr", {24'b0, mem_address}, 32'h05);
    chk("t1_bus", {16'b0, mem_data}, 32'hBEEF);
    chk("t1_rdy_acc", {30'b0, req_ready}, 0);
    step();
    chk("t1_rspv", {30'b0, rsp_valid}, 32'h1);
    chk("t1_rdata", {16'b0, rsp_rdata}, 32'hBEEF);
    chk("t1_re_off", {31'b0, mem_re}, 0);

    // port 1 write 0x12 <- A5A5, then port 0 read 0x12
    req_valid    = 2'b10;
    req_we[1]    = 1'b1;
    req_addr[1]  = 8'h12;
    req_wdata[1] = 16'hA5A5;
    #1 chk("t2_ready_w", {30'b0, req_ready}, 32'h2);
    step();
    idle_in();
    req_valid   = 2'b01;
    req_addr[0] = 8'h12;
    #1;
    chk("t2_we", {31'b0, mem_we}, 1);
    chk("t2_wbus", {16'b0, mem_data}, 32'hA5A5);
    chk("t2_rdy_acc", {30'b0, req_ready}, 0);
    step();
    chk("t2_turn_re", {31'b0, mem_re}, 0);
    chk("t2_turn_we", {31'b0, mem_we}, 0);
    chk("t2_turn_rdy", {30'b0, req_ready}, 0);
    chk("t2_turn_bus", {16'b0, mem_data}, {16'b0, KEEP});
    step();
    chk("t2_ready_r", {30'b0, req_ready}, 32'h1);
    step();
    idle_in();
    #1;
    chk("t2_re", {31'b0, mem_re}, 1);
    step();
    chk("t2_rspv", {30'b0, rsp_valid}, 32'h1);
    chk("t2_rdata", {16'b0, rsp_rdata}, 32'hA5A5);

    // continuous contention, reads only
    pulse_reset();
    req_valid   = 2'b11;
    req_addr[0] = 8'h05;
    req_addr[1] = 8'h06;
    for (int k = 0; k < 4; k++) begin
      logic [1:0]    eg;
      logic [DW-1:0] ed;
      eg = k[0] ? 2'b10 : 2'b01;
      ed = k[0] ? 16'h1234 : 16'hBEEF;
      #1 chk("t3_grant", {30'b0, req_ready}, {30'b0, eg});
      step();
      chk("t3_rdy_acc", {30'b0, req_ready}, 0);
      chk("t3_re", {31'b0, mem_re}, 1);
      step();
      chk("t3_rspv", {30'b0, rsp_valid}, {30'b0, eg});
      chk("t3_rdata", {16'b0, rsp_rdata}, {16'b0, ed});
    end
    idle_in();

    // port 1: write 0x00<-1, write 0x01<-2, read 0x01
    req_valid    = 2'b10;
    req_we[1]    = 1'b1;
    req_addr[1]  = 8'h00;
    req_wdata[1] = 16'h0001;
    #1 chk("t4_ready1", {30'b0, req_ready}, 32'h2);
    step();
    req_addr[1]  = 8'h01;
    req_wdata[1] = 16'h0002;
    #1;
    chk("t4_we1", {31'b0, mem_we}, 1);
    chk("t4_bus1", {16'b0, mem_data}, 32'h0001);
    chk("t4_addr1", {24'b0, mem_address}, 32'h00);
    step();
    chk("t4_no_turn", {30'b0, req_ready}, 32'h2);
    chk("t4_we_idle", {31'b0, mem_we}, 0);
    step();
    req_we[1] = 1'b0;
    #1;
    chk("t4_we2", {31'b0, mem_we}, 1);
    chk("t4_bus2", {16'b0, mem_data}, 32'h0002);
    chk("t4_addr2", {24'b0, mem_address}, 32'h01);
    step();
    chk("t4_turn_rdy", {30'b0, req_ready}, 0);
    chk("t4_turn_we", {31'b0, mem_we}, 0);
    chk("t4_turn_re", {31'b0, mem_re}, 0);
    chk("t4_mem0", {16'b0, mem[0]}, 32'h0001);
    step();
    chk("t4_ready3", {30'b0, req_ready}, 32'h2);
    step();
    idle_in();
    #1;
    chk("t4_re", {31'b0, mem_re}, 1);
    chk("t4_rbus", {16'b0, mem_data}, 32'h0002);
    step();
    chk("t4_rspv", {30'b0, rsp_valid}, 32'h2);
    chk("t4_rdata", {16'b0, rsp_rdata}, 32'h0002);

    // reset in the middle of a write access
    req_valid    = 2'b10;
    req_we[1]    = 1'b1;
    req_addr[1]  = 8'h20;
    req_wdata[1] = 16'hFFFF;
    step();
    idle_in();
    #1 chk("t5_we_pre", {31'b0, mem_we}, 1);
    #2 reset = 1'b1;
    #1;
    chk("t5_we_rst", {31'b0, mem_we}, 0);
    chk("t5_re_rst", {31'b0, mem_re}, 0);
    chk("t5_bus_rst", {16'b0, mem_data}, {16'b0, KEEP});
    chk("t5_addr_rst", {24'b0, mem_address}, 0);
    chk("t5_rspv_rst", {30'b0, rsp_valid}, 0);
    @(posedge clock);
    #2 reset = 1'b0;
    #1 chk("t5_rspv_post", {30'b0, rsp_valid}, 0);
    req_valid   = 2'b11;
    req_addr[0] = 8'h05;
    req_addr[1] = 8'h06;
    #1 chk("t5_first_gnt", {30'b0, req_ready}, 32'h1);
    step();
    idle_in();
    step();
    chk("t5_rspv", {30'b0, rsp_valid}, 32'h1);
    chk("t5_rdata", {16'b0, rsp_rdata}, 32'hBEEF);
    step();
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
